// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Owns PC/IR, shares the RAM port with
//            datapath accesses, stops at HALT. Define FETCH_PREFETCH_EN for a
//            one-entry prefetch buffer.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_pc,
  input  logic               data_req,
  input  logic               data_we,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [INSTR_W-1:0] data_wdata,
  output logic               data_gnt,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  localparam logic [2:0] c_ST_INIT   = 3'd0;
  localparam logic [2:0] c_ST_ISSUE  = 3'd1;
  localparam logic [2:0] c_ST_WAIT   = 3'd2;
  localparam logic [2:0] c_ST_HOLD   = 3'd3;
  localparam logic [2:0] c_ST_HALTED = 3'd4;
  localparam logic [2:0] c_HALT_OP   = 3'b111;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               w_handshake;
  logic               w_is_halt;
  logic               w_fetch_rd;

  assign w_handshake = valid_q & instr_ready;
  assign w_is_halt   = (instr_q[INSTR_W-1 -: 3] == c_HALT_OP);

`ifdef FETCH_PREFETCH_EN
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic               pf_inflight_q, pf_inflight_d;
  logic               w_pf_issue;

  // Prefetch only into an empty buffer and never past a HALT held in instr.
  assign w_pf_issue = (state_q == c_ST_HOLD) && !buf_full_q && !pf_inflight_q &&
                      !w_is_halt && !data_req && !branch_en;
  assign w_fetch_rd = ((state_q == c_ST_ISSUE) && !data_req) || w_pf_issue;
`else
  assign w_fetch_rd = (state_q == c_ST_ISSUE) && !data_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= c_ST_INIT;
      pc_q          <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      pf_inflight_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
`ifdef FETCH_PREFETCH_EN
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      pf_inflight_q <= pf_inflight_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef FETCH_PREFETCH_EN
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    pf_inflight_d = 1'b0;
`endif
    case (state_q)
      c_ST_INIT: begin
        pc_d    = start_pc;
        state_d = c_ST_ISSUE;
      end
      c_ST_ISSUE: begin
        if (branch_en) begin
          pc_d = branch_pc;
        end else if (!data_req) begin
          state_d = c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        if (branch_en) begin
          pc_d    = branch_pc;
          valid_d = 1'b0;
          state_d = c_ST_ISSUE;
        end else begin
          instr_d = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          valid_d = 1'b1;
          state_d = c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        // A consumed HALT beats a same-cycle branch.
        if (w_handshake && w_is_halt) begin
          valid_d = 1'b0;
          state_d = c_ST_HALTED;
        end else if (branch_en) begin
          pc_d    = branch_pc;
          valid_d = 1'b0;
          state_d = c_ST_ISSUE;
`ifdef FETCH_PREFETCH_EN
          buf_full_d = 1'b0;
`endif
        end else if (w_handshake) begin
`ifdef FETCH_PREFETCH_EN
          if (buf_full_q) begin
            instr_d    = buf_q;
            buf_full_d = 1'b0;
          end else if (pf_inflight_q) begin
            instr_d = mem_rdata;
            pc_d    = pc_q + ADDR_W'(1);
          end else if (w_pf_issue) begin
            valid_d = 1'b0;
            state_d = c_ST_WAIT;
          end else begin
            valid_d = 1'b0;
            state_d = c_ST_ISSUE;
          end
`else
          valid_d = 1'b0;
          state_d = c_ST_ISSUE;
`endif
        end
`ifdef FETCH_PREFETCH_EN
        else if (pf_inflight_q) begin
          buf_d      = mem_rdata;
          buf_full_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
        end else if (w_pf_issue) begin
          pf_inflight_d = 1'b1;
        end
`endif
      end
      c_ST_HALTED: begin
      end
      default: state_d = c_ST_INIT;
    endcase
  end

  always_comb begin
    data_gnt  = data_req && ((state_q == c_ST_ISSUE) || (state_q == c_ST_HOLD) ||
                             (state_q == c_ST_HALTED));
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (data_gnt) begin
      mem_addr  = data_addr;
      mem_we    = data_we;
      mem_wdata = data_wdata;
      mem_rd    = ~data_we;
    end else if (w_fetch_rd) begin
      mem_addr = pc_q;
      mem_rd   = 1'b1;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == c_ST_HALTED);
  assign pc          = pc_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the simple RISC machine. It sits directly upstream of the controller/decoder. It owns the PC and the instruction register, and issues reads to the shared 256×16 synchronous RAM. It hands each fetched 16-bit instruction downstream over a valid/ready handshake. It arbitrates the RAM port with load/store data accesses from the datapath, and stops fetching at a HALT instruction.

## Interface
Parameters:
- `ADDR_W`, default 8: PC and memory address width.
- `INSTR_W`, default 16: instruction and data width.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start_pc`, in, 8: initial PC, loaded on the first cycle after `rst` deasserts.
- `instr`, out, 16: current instruction register.
- `instr_valid`, out, 1: `instr` holds an undelivered instruction.
- `instr_ready`, in, 1: downstream accepts `instr` this cycle.
- `branch_en`, in, 1: redirect the PC.
- `branch_pc`, in, 8: redirect target.
- `data_req`, in, 1: datapath requests the RAM port.
- `data_we`, in, 1: write strobe for the data request.
- `data_addr`, in, 8: data access address.
- `data_wdata`, in, 16: store data.
- `data_gnt`, out, 1: data request owns the RAM port this cycle (combinational).
- `mem_addr`, out, 8: RAM address.
- `mem_rd`, out, 1: RAM read strobe.
- `mem_we`, out, 1: RAM write strobe.
- `mem_wdata`, out, 16: RAM write data.
- `mem_rdata`, in, 16: RAM read data, valid one cycle after `mem_rd`.
- `halted`, out, 1: a HALT instruction was delivered and fetching has stopped.
- `pc`, out, 8: address of the next fetch.

## Operation
FSM states:
- **INIT**: `pc <= start_pc`, then go to ISSUE.
- **ISSUE**: if `data_req`=0, drive `mem_rd`=1 with `mem_addr`=`pc`, then go to WAIT. Otherwise grant the data access and stay in ISSUE.
- **WAIT**: `instr <= mem_rdata`, `pc <= pc+1` (mod 256), `instr_valid <= 1`, then go to HOLD. `data_gnt`=0 in WAIT.
- **HOLD**: when `instr_valid & instr_ready`, the instruction is consumed.
  - If the consumed instruction has `instr[15:13]`=3'b111 (HALT), go to HALTED.
  - Otherwise go to ISSUE.
- **HALTED**: `halted`=1, no fetches. Data requests are still granted. Exit only via `rst`.

Port arbitration and RAM outputs:
- When `data_gnt`=1: `mem_addr`=`data_addr`, `mem_we`=`data_we`, `mem_wdata`=`data_wdata`, `mem_rd`=`~data_we`.
- When `data_gnt`=0: `mem_we`=0.
- Read data for a granted data access appears on `mem_rdata` the next cycle. This block ignores it.
- `data_gnt` = `data_req` & state ∈ {ISSUE, HOLD, HALTED}.

Branch redirect:
- `branch_en` in ISSUE/WAIT/HOLD sets `pc <= branch_pc`, clears `instr_valid`, discards any in-flight read, and moves to ISSUE.
- `branch_en` is ignored in INIT and HALTED.
- If a handshake and `branch_en` occur in the same cycle, the handshake completes and `branch_pc` wins the PC.
- A branch in the same cycle as consuming a HALT: HALT wins, and the block goes to HALTED.

Arithmetic and outputs:
- PC increment wraps 8'hFF→8'h00.
- `instr` holds its value while `instr_valid`=1 and `instr_ready`=0.

## Timing
Reset values:
- State = INIT, `pc`=0, `instr`=16'h0000, `instr_valid`=0, `halted`=0.
- `mem_rd`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `data_gnt`=0.

Fetch latency and throughput:
- The fetch is issued 2 cycles after `rst` falls (INIT, then ISSUE).
- `instr_valid` rises 2 cycles after an ungranted ISSUE.
- Non-prefetch throughput is at most 1 instruction per 3 cycles with `instr_ready` held high.
- Each cycle spent in ISSUE with `data_req`=1 delays the fetch by one cycle.

Reset mid-operation:
- `rst` asserted in any state aborts immediately: outputs return to reset values asynchronously.
- The in-flight RAM result is dropped.

## Configuration
`FETCH_PREFETCH_EN`:
- **Defined**: adds a one-entry prefetch buffer. While in HOLD with the buffer empty, the last delivered instruction not HALT, and `data_req`=0, the block issues a read of `pc`. The data is captured into the buffer the next cycle and `pc` increments. On a handshake with the buffer full, the buffer moves to `instr` and `instr_valid` stays 1. This gives sustained throughput of 1 instruction per 2 cycles.
  - The block never prefetches past a HALT currently held in `instr`.
  - `branch_en` flushes the buffer and rewinds nothing: `pc` is set to `branch_pc`.
- **Undefined**: no buffer, and behaviour is exactly as in Operation.

## Test plan
- **Reset and first fetch**: RAM[5]=16'hA123, `start_pc`=5, release `rst` → `mem_rd`=1 with `mem_addr`=5 on cycle 2, `instr`=16'hA123 and `instr_valid`=1 on cycle 4, `pc`=6.
- **Stall**: hold `instr_ready`=0 for 10 cycles → `instr` stable at 16'hA123, no new `mem_rd`. Pulse `instr_ready` → next fetch at address 6.
- **Arbitration**: `data_req`=1, `data_we`=1, `data_addr`=8'h20, `data_wdata`=16'h00C3 during ISSUE → `data_gnt`=1, `mem_we`=1, `mem_addr`=8'h20, and the fetch is delayed exactly one cycle.
- **Branch**: `branch_en`=1, `branch_pc`=8'h40 during WAIT → the in-flight instruction is discarded, the next `mem_addr` is 8'h40, and `instr_valid` stays 0 until RAM[8'h40] arrives.
- **Wrap and halt**: `start_pc`=8'hFF, RAM[FF]=16'h6000, RAM[00]=16'hE000 → deliver both, then `pc`=1 and `halted`=1, with no further `mem_rd`. A subsequent `data_req` read is still granted.
- **Prefetch** (with `FETCH_PREFETCH_EN`), `instr_ready`=1 constantly → `instr_valid` edges show 1 instruction per 2 cycles, and there is no fetch beyond the HALT address.
